ps_inv_seq: RTL and testbench

//  Inverse of the ASCON substitution layer, sequential form. Accepts a full 320-bit

---
 rtl/ps_inv_seq.sv | 160 ++++++++++++++++
 tb/tb_ps_inv_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_inv_seq.sv
// ps_inv_seq: inverse ASCON substitution layer, COLS_PER_CYCLE columns/clock.
// Optional self-check of every inverted column: define PS_INV_SELFCHECK_EN.
//
// Ports:
//   clock_i   rising-edge clock
//   resetb_i  async active-low reset
//   start_i   request; state_i captured when accepted (IDLE or DONE)
//   state_i   320-bit state, row r at bits [(4-r)*64 +: 64]
//   state_o   working/result register
//   busy_o    high while columns are processed
//   done_o    one-cycle pulse, state_o holds the full result
//   err_o     sticky self-check error (0 when the check is not built)
module ps_inv_seq #(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int C     = COLS_PER_CYCLE;
    localparam int NSTEP = 64 / C;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int LC    = $clog2(C);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);
    localparam logic [63:0]   MASK = {64{1'b1}} >> (64 - C);

    localparam logic [4:0] INV_TAB [32] = '{
        5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
        5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
        5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
        5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
    };

`ifdef PS_INV_SELFCHECK_EN
    localparam logic [4:0] FWD_TAB [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };
    logic mism;
    logic err_q, err_d;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [319:0]  work_q, work_d;

    logic [5:0]    base;
    logic [63:0]   rows   [5];
    logic [C-1:0]  sl     [5];
    logic [C-1:0]  inv_sl [5];
    logic [63:0]   upd    [5];
    logic [4:0]    col, icol;
    logic [319:0]  work_run;

    // Slice out the C columns selected by cnt, invert them, splice back.
    always_comb begin
        base = 6'(cnt_q) << LC;
        col  = '0;
        icol = '0;
`ifdef PS_INV_SELFCHECK_EN
        mism = 1'b0;
`endif
        for (int r = 0; r < 5; r++) begin
            rows[r]   = work_q[(4-r)*64 +: 64];
            sl[r]     = C'(rows[r] >> base);
            inv_sl[r] = '0;
        end
        for (int j = 0; j < C; j++) begin
            col  = {sl[0][j], sl[1][j], sl[2][j], sl[3][j], sl[4][j]};
            icol = INV_TAB[col];
            for (int r = 0; r < 5; r++) begin
                inv_sl[r][j] = icol[4-r];
            end
`ifdef PS_INV_SELFCHECK_EN
            mism = mism | (FWD_TAB[icol] != col);
`endif
        end
        for (int r = 0; r < 5; r++) begin
            upd[r] = (rows[r] & ~(MASK << base))
                   | (64'(inv_sl[r]) << base);
        end
        work_run = {upd[0], upd[1], upd[2], upd[3], upd[4]};
    end

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        work_d = work_q;
`ifdef PS_INV_SELFCHECK_EN
        err_d  = err_q;
`endif
        unique case (fsm_q)
            IDLE, DONE: begin
                if (start_i) begin
                    work_d = state_i;
                    cnt_d  = '0;
                    fsm_d  = RUN;
`ifdef PS_INV_SELFCHECK_EN
                    err_d  = 1'b0;
`endif
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                work_d = work_run;
`ifdef PS_INV_SELFCHECK_EN
                err_d  = err_q | mism;
`endif
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
        end
    end

`ifdef PS_INV_SELFCHECK_EN
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign state_o = work_q;
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_ps_inv_seq.sv
// tb_ps_inv_seq: directed bench for ps_inv_seq at 8, 1 and 64 cols/cycle.
// Expected results come from the forward ASCON S-box and hand constants.
module tb_ps_inv_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [319:0] st_in;
    logic         start [3];
    logic [319:0] so    [3];
    logic         busy  [3];
    logic         done  [3];
    logic         err   [3];

    int n_checks = 0;
    int n_fail   = 0;

    ps_inv_seq #(.COLS_PER_CYCLE(8)) u8 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start[0]),
        .state_i(st_in), .state_o(so[0]), .busy_o(busy[0]),
        .done_o(done[0]), .err_o(err[0])
    );
    ps_inv_seq #(.COLS_PER_CYCLE(1)) u1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start[1]),
        .state_i(st_in), .state_o(so[1]), .busy_o(busy[1]),
        .done_o(done[1]), .err_o(err[1])
    );
    ps_inv_seq #(.COLS_PER_CYCLE(64)) u64 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start[2]),
        .state_i(st_in), .state_o(so[2]), .busy_o(busy[2]),
        .done_o(done[2]), .err_o(err[2])
    );

    function automatic int lat(input int k);
        case (k)
            0:       return 9;
            1:       return 65;
            default: return 2;
        endcase
    endfunction

    function automatic logic [4:0] fsb(input logic [4:0] x);
        case (x)
            5'd0:  return 5'd4;   5'd1:  return 5'd11;
            5'd2:  return 5'd31;  5'd3:  return 5'd20;
            5'd4:  return 5'd26;  5'd5:  return 5'd21;
            5'd6:  return 5'd9;   5'd7:  return 5'd2;
            5'd8:  return 5'd27;  5'd9:  return 5'd5;
            5'd10: return 5'd8;   5'd11: return 5'd18;
            5'd12: return 5'd29;  5'd13: return 5'd3;
            5'd14: return 5'd6;   5'd15: return 5'd28;
            5'd16: return 5'd30;  5'd17: return 5'd19;
            5'd18: return 5'd7;   5'd19: return 5'd14;
            5'd20: return 5'd0;   5'd21: return 5'd13;
            5'd22: return 5'd17;  5'd23: return 5'd24;
            5'd24: return 5'd16;  5'd25: return 5'd12;
            5'd26: return 5'd1;   5'd27: return 5'd25;
            5'd28: return 5'd22;  5'd29: return 5'd10;
            5'd30: return 5'd15;  default: return 5'd23;
        endcase
    endfunction

    // Forward substitution layer, row 0 in the top 64 bits.
    function automatic logic [319:0] fwd_ps(input logic [319:0] s);
        logic [319:0] o;
        logic [4:0]   c, y;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            c = {s[256+i], s[192+i], s[128+i], s[64+i], s[i]};
            y = fsb(c);
            {o[256+i], o[192+i], o[128+i], o[64+i], o[i]} = y;
        end
        return o;
    endfunction

    function automatic logic [319:0] rnd();
        logic [319:0] r;
        r = '0;
        for (int w = 0; w < 10; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_one(input int k, input logic [319:0] st,
                           output logic [319:0] res, output int cyc);
        @(negedge clk);
        st_in    = st;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        cyc = 1;
        n_checks++;
        if (busy[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first dut%0d: got %b want 1", k, busy[k]);
        end
        while (done[k] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        res = so[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st_in = '0;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({busy[k], done[k], err[k]} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: got %b want 000",
                         k, {busy[k], done[k], err[k]});
            end
            n_checks++;
            if (so[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got %h want 0", k, so[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_const(input logic [319:0] in,
                              input logic [319:0] exp, input string nm);
        logic [319:0] res;
        int cyc;
        run_one(0, in, res, cyc);
        n_checks++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want 9", nm, cyc);
        end
        n_checks++;
        if (res !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got %h want %h", nm, res, exp);
        end
        n_checks++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err: got %b want 0", nm, err[0]);
        end
        @(negedge clk);
        n_checks++;
        if (done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: got %b want 0", nm, done[0]);
        end
    endtask

    task automatic test_round_trip(input int k, input int n);
        logic [319:0] x, res;
        int cyc;
        for (int i = 0; i < n; i++) begin
            x = rnd();
            run_one(k, fwd_ps(x), res, cyc);
            n_checks++;
            if (res !== x || cyc != lat(k) || err[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL round_trip dut%0d #%0d: got %h cyc %0d err %b want %h cyc %0d err 0",
                         k, i, res, cyc, err[k], x, lat(k));
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [319:0] a, b;
        int cyc, pulses;
        a = rnd();
        b = rnd();
        @(negedge clk);
        st_in    = fwd_ps(a);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 1;
        while (done[0] !== 1'b1 && cyc < 40) begin
            if (cyc == 3 || cyc == 5) begin
                st_in    = fwd_ps(b);
                start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start[0] = 1'b0;
        n_checks++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d want 9", cyc);
        end
        n_checks++;
        if (so[0] !== a) begin
            n_fail++;
            $display("FAIL ignore_result: got %h want %h", so[0], a);
        end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL ignore_extra_activity: got %0d cycles want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [319:0] a, b, res;
        int cyc;
        a = rnd();
        b = rnd();
        @(negedge clk);
        st_in    = fwd_ps(a);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_busy: got %b want 1", busy[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy[0], done[0], err[0]} !== 3'b000 || so[0] !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: flags %b state %h want 000 and 0",
                     {busy[0], done[0], err[0]}, so[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: busy %b done %b want 0 0", busy[0], done[0]);
        end
        run_one(0, fwd_ps(b), res, cyc);
        n_checks++;
        if (res !== b || cyc != 9) begin
            n_fail++;
            $display("FAIL midrst_after: got %h cyc %0d want %h cyc 9", res, cyc, b);
        end
    endtask

    task automatic test_back_to_back(input int k);
        logic [319:0] x;
        int cyc, prev, pulses, l;
        x = rnd();
        l = lat(k);
        cyc = 0;
        prev = 0;
        pulses = 0;
        @(negedge clk);
        st_in    = fwd_ps(x);
        start[k] = 1'b1;
        while (pulses < 3 && cyc < 4*l + 4) begin
            @(negedge clk);
            cyc++;
            if (done[k] === 1'b1) begin
                n_checks++;
                if (cyc - prev != l) begin
                    n_fail++;
                    $display("FAIL b2b_period dut%0d: got %0d want %0d", k, cyc - prev, l);
                end
                n_checks++;
                if (so[k] !== x) begin
                    n_fail++;
                    $display("FAIL b2b_result dut%0d: got %h want %h", k, so[k], x);
                end
                prev = cyc;
                pulses++;
                if (pulses == 3) start[k] = 1'b0;
            end
        end
        start[k] = 1'b0;
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulses dut%0d: got %0d want 3", k, pulses);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle dut%0d: got busy %b want 0", k, busy[k]);
        end
    endtask

    initial begin
        test_reset();
        test_const('0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                        64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0}, "zeros");
        test_const({320{1'b1}}, {64'h0, 64'h0, 64'h0,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, "ones");
        test_round_trip(0, 200);
        test_round_trip(1, 16);
        test_round_trip(2, 16);
        test_ignore_start();
        test_reset_mid();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
